// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite slave backed by word-addressed on-chip memory, with fixed wait states and a two-cycle ERROR response.
// Optional: define AHB_SLV_PROT_CHECK_EN to reject unprivileged writes (HPROT[1]=0) with an ERROR response.
module ahb_lite_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  HRESETn,
  input  logic                  HSELx,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int SIZE_MAX = $clog2(BYTES);
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state, state_next;
  logic [2:0] wait_cnt, wait_cnt_next;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] addr_word;
  logic                  range_err, size_err, align_err, prot_err, xfer_err;
  logic [IDX_W-1:0]      live_idx, idx_q, rd_idx;
  logic [BYTES-1:0]      live_be, be_q;
  logic                  write_q, commit, rd_sel, load_rd;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  unused_inputs;

  assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT};

  // HREADYOUT gates acceptance so an address held during WAIT/ERR1 is never sampled early.
  assign accept    = HSELx & HREADY & HREADYOUT & HTRANS[1];
  assign addr_word = HADDR >> SIZE_MAX;
  assign live_idx  = addr_word[IDX_W-1:0];
  assign range_err = addr_word >= ADDR_WIDTH'(DEPTH);
  assign size_err  = HSIZE > 3'(SIZE_MAX);
  assign align_err = (HADDR & ((ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1))) != '0;
`ifdef AHB_SLV_PROT_CHECK_EN
  assign prot_err  = HWRITE & ~HPROT[1];
`else
  assign prot_err  = 1'b0;
`endif
  assign xfer_err  = range_err | size_err | align_err | prot_err;

  always_comb begin
    live_be = '0;
    for (int b = 0; b < BYTES; b++) begin
      live_be[b] = (b >= int'(HADDR[SIZE_MAX-1:0])) &&
                   (b < int'(HADDR[SIZE_MAX-1:0]) + (1 << HSIZE));
    end
  end

  assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_next = ST_IDLE;
        if (accept) begin
          if (xfer_err) begin
            state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = 3'(WAIT_STATES - 1);
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 3'd0) state_next = ST_DATA;
        else                  wait_cnt_next = wait_cnt - 3'd1;
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      write_q <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
    end else if (accept) begin
      write_q <= HWRITE;
      idx_q   <= live_idx;
      be_q    <= live_be;
    end
  end

  // A read enters DATA either straight from acceptance (live address) or from WAIT (latched address).
  assign commit  = (state == ST_DATA) && write_q;
  assign rd_sel  = accept ? ~HWRITE : ~write_q;
  assign rd_idx  = accept ? live_idx : idx_q;
  assign load_rd = (state_next == ST_DATA) && rd_sel;

  always_comb begin
    rd_word = mem[rd_idx];
    if (commit && (rd_idx == idx_q)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn)     HRDATA <= '0;
    else if (load_rd) HRDATA <= rd_word;
  end

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Scoreboard bench: slave 0 has two wait states, slave 1 has none; a negedge monitor checks every completed transfer.
module tb_ahb_lite_slave_mem;

  logic        clk;
  logic        HRESETn;
  logic [1:0]  sel;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [1:0]        rdyo;
  logic [1:0][1:0]   resp;
  logic [1:0][31:0]  rdata;

  typedef struct {
    int          d;
    int          id;
    logic        wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   xfer_id = 0;
  int   in_data [2];
  int   low_cnt [2];
  logic [1:0] wait_resp [2];

  ahb_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(2)) dut0 (
    .clk(clk), .HRESETn(HRESETn), .HSELx(sel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HREADY(rdyo[0]), .HRDATA(rdata[0]), .HREADYOUT(rdyo[0]), .HRESP(resp[0])
  );

  ahb_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dut1 (
    .clk(clk), .HRESETn(HRESETn), .HSELx(sel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HREADY(rdyo[1]), .HRDATA(rdata[1]), .HREADYOUT(rdyo[1]), .HRESP(resp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Completion is seen at the negedge of the data-phase cycle in which HREADYOUT is high.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!HRESETn) begin
        in_data[d] = 0;
      end else begin
        if (in_data[d] != 0) begin
          if (!rdyo[d]) begin
            if (low_cnt[d] == 0) wait_resp[d] = resp[d];
            low_cnt[d]++;
          end else begin
            in_data[d] = 0;
            if (exp_q.size() == 0) begin
              check_output($sformatf("unexpected completion dut%0d", d), 32'd1, 32'd0);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              check_output($sformatf("xfer%0d target", e.id), 32'(d), 32'(e.d));
              check_output($sformatf("xfer%0d HRESP", e.id), 32'(resp[d]), 32'(e.resp));
              check_output($sformatf("xfer%0d wait cycles", e.id), 32'(low_cnt[d]), 32'(e.waits));
              if (e.waits > 0)
                check_output($sformatf("xfer%0d HRESP in wait", e.id), 32'(wait_resp[d]), 32'(e.resp));
              if (!e.wr && e.resp == 2'b00)
                check_output($sformatf("xfer%0d HRDATA", e.id), rdata[d], e.rdata);
            end
          end
        end
        if (sel[d] && HTRANS[1] && rdyo[d]) begin
          in_data[d] = 1;
          low_cnt[d] = 0;
        end
      end
    end
  end

  task automatic apply_stimulus(input int d, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata, input logic [3:0] prot,
                                input logic [1:0] exp_resp, input logic [31:0] exp_rdata);
    exp_t e;
    logic rdy;
    int   n;
    sel       = 2'b00;
    sel[d]    = 1'b1;
    HADDR     = addr;
    HTRANS    = 2'b10;
    HWRITE    = wr;
    HSIZE     = size;
    HPROT     = prot;
    e.d       = d;
    e.id      = xfer_id;
    e.wr      = wr;
    e.resp    = exp_resp;
    e.rdata   = exp_rdata;
    e.waits   = (exp_resp == 2'b01) ? 1 : ((d == 0) ? 2 : 0);
    exp_q.push_back(e);
    xfer_id++;
    n = 0;
    do begin
      @(negedge clk);
      rdy = rdyo[d];
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check_output($sformatf("xfer%0d accept timeout", e.id), 32'd0, 32'd1);
    HWDATA = wdata;
    sel    = 2'b00;
    HTRANS = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check_output("drain timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0; sel = 2'b00; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HBURST = 3'd0; HPROT = 4'b0011; HMASTLOCK = 1'b0; HWDATA = '0;
    repeat (3) @(posedge clk);
    #1 HRESETn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("reset HREADYOUT dut%0d", d), 32'(rdyo[d]), 32'd1);
      check_output($sformatf("reset HRESP dut%0d", d), 32'(resp[d]), 32'd0);
      check_output($sformatf("reset HRDATA dut%0d", d), rdata[d], 32'd0);
    end

    // Selected but IDLE: no wait states, no error.
    @(posedge clk); #1;
    sel = 2'b10; HTRANS = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("idle HREADYOUT", 32'(rdyo[1]), 32'd1);
    check_output("idle HRESP", 32'(resp[1]), 32'd0);
    @(posedge clk); #1;
    sel = 2'b00;

    // Two wait states: word write and read-back.
    apply_stimulus(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 4'b0011, 2'b00, 32'h0);
    apply_stimulus(0, 1'b0, 32'h10, 3'd2, 32'h0,        4'b0011, 2'b00, 32'hDEADBEEF);
    drain();

    // Byte lanes: garbage in unselected lanes must be masked.
    apply_stimulus(0, 1'b1, 32'h20, 3'd2, 32'hAABBCCDD, 4'b0011, 2'b00, 32'h0);
    apply_stimulus(0, 1'b1, 32'h21, 3'd0, 32'hFFFF11FF, 4'b0011, 2'b00, 32'h0);
    apply_stimulus(0, 1'b1, 32'h23, 3'd0, 32'h22EEEEEE, 4'b0011, 2'b00, 32'h0);
    apply_stimulus(0, 1'b0, 32'h20, 3'd2, 32'h0,        4'b0011, 2'b00, 32'h22BB11DD);
    drain();

    // Error cases never touch memory.
    apply_stimulus(0, 1'b1, 32'h0,    3'd2, 32'h01020304, 4'b0011, 2'b00, 32'h0);
    drain();
    apply_stimulus(0, 1'b1, 32'h1000, 3'd2, 32'hFFFFFFFF, 4'b0011, 2'b01, 32'h0);
    drain();
    apply_stimulus(0, 1'b0, 32'h1000, 3'd2, 32'h0,        4'b0011, 2'b01, 32'h0);
    drain();
    apply_stimulus(0, 1'b1, 32'h11,   3'd1, 32'h00FFFF00, 4'b0011, 2'b01, 32'h0);
    drain();
    apply_stimulus(0, 1'b0, 32'h1,    3'd1, 32'h0,        4'b0011, 2'b01, 32'h0);
    drain();
    apply_stimulus(0, 1'b1, 32'h10,   3'd3, 32'h0BADF00D, 4'b0011, 2'b01, 32'h0);
    drain();
    apply_stimulus(0, 1'b1, 32'h12,   3'd2, 32'h0BADF00D, 4'b0011, 2'b01, 32'h0);
    drain();
    apply_stimulus(0, 1'b0, 32'h0,    3'd2, 32'h0,        4'b0011, 2'b00, 32'h01020304);
    apply_stimulus(0, 1'b0, 32'h10,   3'd2, 32'h0,        4'b0011, 2'b00, 32'hDEADBEEF);
    drain();

    // Zero wait states: read right behind a write to the same word is forwarded.
    apply_stimulus(1, 1'b1, 32'h40, 3'd2, 32'h12345678, 4'b0011, 2'b00, 32'h0);
    apply_stimulus(1, 1'b0, 32'h40, 3'd2, 32'h0,        4'b0011, 2'b00, 32'h12345678);
    apply_stimulus(1, 1'b1, 32'h42, 3'd1, 32'hABCD0000, 4'b0011, 2'b00, 32'h0);
    apply_stimulus(1, 1'b0, 32'h40, 3'd2, 32'h0,        4'b0011, 2'b00, 32'hABCD5678);
    apply_stimulus(1, 1'b1, 32'h44, 3'd2, 32'h55555555, 4'b0011, 2'b00, 32'h0);
    apply_stimulus(1, 1'b1, 32'h48, 3'd2, 32'h66666666, 4'b0011, 2'b00, 32'h0);
    apply_stimulus(1, 1'b0, 32'h44, 3'd2, 32'h0,        4'b0011, 2'b00, 32'h55555555);
    drain();

    // Unprivileged write; reads with the same HPROT are never rejected.
    apply_stimulus(1, 1'b1, 32'h8, 3'd2, 32'hCAFEF00D, 4'b0011, 2'b00, 32'h0);
    drain();
`ifdef AHB_SLV_PROT_CHECK_EN
    apply_stimulus(1, 1'b1, 32'h8, 3'd2, 32'hBAADBAAD, 4'b0001, 2'b01, 32'h0);
    drain();
    apply_stimulus(1, 1'b0, 32'h8, 3'd2, 32'h0,        4'b0001, 2'b00, 32'hCAFEF00D);
`else
    apply_stimulus(1, 1'b1, 32'h8, 3'd2, 32'hBAADBAAD, 4'b0001, 2'b00, 32'h0);
    drain();
    apply_stimulus(1, 1'b0, 32'h8, 3'd2, 32'h0,        4'b0001, 2'b00, 32'hBAADBAAD);
`endif
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ahb_lite_slave_mem.md
# ahb_lite_slave_mem

Parametrised AHB-Lite slave: word-addressed on-chip memory with configurable data width, depth and fixed wait-state insertion, driving HREADYOUT and a two-cycle ERROR response. It is the memory-side endpoint that the AHB driver/monitor agents exercise. It replaces ad-hoc fixed-width response models and sits behind the bus decoder, which drives HSELx.

## Interface
- ADDR_WIDTH, 32: width of HADDR.
- DATA_WIDTH, 32: width of HWDATA and HRDATA; legal values are 32 and 64.
- DEPTH, 1024: memory depth in DATA_WIDTH-bit words.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted per OKAY transfer; legal range 0..7.
- clk  in  1  bus clock; all state changes on its rising edge.
- HRESETn  in  1  reset, asynchronous assert, active-low.
- HSELx  in  1  slave select from the decoder.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, log2 of the byte count.
- HBURST  in  3  burst type; accepted, not decoded.
- HPROT  in  4  protection; bit 1 = privileged.
- HMASTLOCK  in  1  accepted, ignored.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; an address phase is sampled only while it is 1.
- HRDATA  out  DATA_WIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  OKAY=00, ERROR=01.

## Operation
- A transfer is accepted on a rising edge with HSELx=1, HREADY=1 and HTRANS[1]=1. On acceptance the block latches the address, HWRITE, HSIZE and HPROT.
- IDLE/BUSY transfers, or no selection: zero-wait OKAY response, no memory access.
- Error conditions on an accepted transfer, any one of which applies:
  - word index (HADDR >> log2(DATA_WIDTH/8)) >= DEPTH;
  - HSIZE > log2(DATA_WIDTH/8);
  - HADDR not aligned to 2^HSIZE.
- An errored transfer never touches memory.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=OKAY.
  - WAIT: HREADYOUT=0, HRESP=OKAY; the wait counter decrements.
  - DATA: HREADYOUT=1, HRESP=OKAY.
  - ERR1: HREADYOUT=0, HRESP=ERROR.
  - ERR2: HREADYOUT=1, HRESP=ERROR.
- FSM transitions:
  - Accept, clean, WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
  - Accept, clean, WAIT_STATES=0 -> DATA.
  - Accept, errored -> ERR1 -> ERR2.
  - WAIT with counter 0 -> DATA.
  - DATA or ERR2 -> next accept target as above, else IDLE (back-to-back pipelining).
- Write: active byte lanes are selected from HSIZE and the low address bits, little-endian. HWDATA is sampled and memory updated at the rising edge that ends the DATA cycle.
- Read: the memory word is registered into HRDATA at the edge entering DATA and held until the next read. The full word is driven regardless of HSIZE.
- Read-after-write forwarding: if a read is accepted at the same edge that commits a write to the same word, HRDATA takes the written byte lanes merged over the old word.
- HRDATA is not cleared between transfers.

## Timing
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, wait counter=0.
- Memory contents are not reset.
- Latency from address phase to completion is WAIT_STATES+1 cycles for OKAY transfers and 2 cycles for ERROR.
- During ERR1 and WAIT, HREADYOUT=0 blocks new address sampling. Held address-phase signals are ignored until HREADYOUT returns to 1.
- A new address phase in ERR2 is accepted normally. Masters are expected to drive IDLE there; the slave does not cancel the transfer.
- HRESETn assertion mid-transfer forces the reset values asynchronously. A write whose DATA-ending edge has not occurred is dropped.

## Configuration
- AHB_SLV_PROT_CHECK_EN defined: an accepted write with HPROT[1]=0 is an additional error condition. It receives the ERR1/ERR2 response and memory is not written. Reads are unaffected.
- Macro undefined: HPROT is ignored entirely.

## Test plan
- Reset with HRESETn=0, then release -> HREADYOUT=1, HRESP=00, HRDATA=0 on the first post-reset edge.
- WAIT_STATES=2, 32-bit: write 0xDEADBEEF to 0x10, then read 0x10 -> HREADYOUT low for exactly 2 cycles per transfer, HRDATA=0xDEADBEEF, HRESP=00.
- Byte writes 0x11 to 0x21 and 0x22 to 0x23 over a word holding 0xAABBCCDD -> word read at 0x20 returns 0x22BB11DD.
- Read at index DEPTH (0x1000 for DEPTH=1024, 32-bit), or halfword at 0x1 -> HRESP=01 with HREADYOUT 0 then 1, and memory is unchanged.
- WAIT_STATES=0, back-to-back write 0x12345678 to 0x40 followed by read of 0x40 -> HRDATA=0x12345678 through forwarding.
- With AHB_SLV_PROT_CHECK_EN, write with HPROT=4'b0001 to 0x8 -> ERROR response and a later read returns the old value. Without the macro -> OKAY and the write lands.
